// File: rtl/fft_byte_packer_pkg.sv
// Shared constants and types for the FFT byte packer: sync byte, bytes per
// sample, serializer states and the bit layout of a buffered sample entry.
package fft_pkg;

  localparam logic [7:0] SYNC_BYTE        = 8'hA5;
  localparam int         BYTES_PER_SAMPLE = 8;

  // Entry layout {last, first, re, im} for 32-bit re/im
  localparam int SAMPLE_W  = 32;
  localparam int IM_LSB    = 0;
  localparam int RE_LSB    = SAMPLE_W;
  localparam int FIRST_BIT = 2*SAMPLE_W;
  localparam int LAST_BIT  = 2*SAMPLE_W + 1;
  localparam int ENTRY_W   = 2*SAMPLE_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/fft_byte_packer_sync_fifo.sv
// Single-clock FIFO with registered read data. The head entry's PEEK_BIT is
// also exposed so the consumer can steer on a flag before the pop lands.
module sync_fifo #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 16,
  parameter  int PEEK_BIT = 0,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_peek,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             w_do_push, w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_rdata;
  assign o_peek    = r_mem[r_rptr][PEEK_BIT];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers, occupancy and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fft_byte_packer.sv
// Buffers FFT result samples and serializes each as 8 bytes (re then im,
// MSB first) onto a valid/ready byte link, with a sync byte before index 0.
module fft_byte_packer
  import fft_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic              in_valid,
  input  logic [15:0]       in_index,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              frame_done
);

  localparam int          EW       = 2*DATA_W + 2;
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  logic [EW-1:0]       w_wdata, w_rdata;
  logic [2*DATA_W-1:0] w_data;
  logic [CW-1:0]       w_fifo_count;
  logic                w_full, w_empty, w_push, w_pop, w_head_first;
  state_t              r_state, w_state_nxt;
  logic [2:0]          r_cnt, w_cnt_nxt;
  logic                r_overflow, r_frame_done, w_frame_done_nxt;
  logic                w_unused;

  assign w_wdata    = {in_index == LAST_IDX, in_index == 16'd0, in_re, in_im};
  assign w_push     = in_valid && !w_full;
  assign w_data     = w_rdata[2*DATA_W-1:0];
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;
  assign w_unused   = ^{w_rdata[FIRST_BIT], w_fifo_count};

  sync_fifo #(
    .WIDTH   (EW),
    .DEPTH   (FIFO_DEPTH),
    .PEEK_BIT(FIRST_BIT)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_wdata(w_wdata),
    .i_pop  (w_pop),
    .o_rdata(w_rdata),
    .o_peek (w_head_first),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_fifo_count)
  );

  // State, byte counter and sticky/pulse flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // Next state: pop when idle or right after the final byte of a sample,
  // steering to SYNC by peeking the head's first flag
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_pop            = 1'b0;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_head_first ? SYNC : SEND;
        end
      end
      SYNC: begin
        if (out_ready) w_state_nxt = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (r_cnt == 3'(BYTES_PER_SAMPLE - 1)) begin
            w_frame_done_nxt = w_rdata[LAST_BIT];
            w_cnt_nxt        = '0;
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_state_nxt = w_head_first ? SYNC : SEND;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so they hold while stalled
  always_comb begin
    out_valid = 1'b0;
    out_byte  = 8'h00;
    case (r_state)
      SYNC: begin
        out_valid = 1'b1;
        out_byte  = SYNC_BYTE;
      end
      SEND: begin
        out_valid = 1'b1;
        out_byte  = w_data[8*(BYTES_PER_SAMPLE - 1 - int'(r_cnt)) +: 8];
      end
      default: begin
        out_valid = 1'b0;
        out_byte  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_fft_byte_packer.sv
// Randomized bench for fft_byte_packer against a byte-queue reference model.
module tb_fft_byte_packer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int FLEN  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_re = '0, in_im = '0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_index = '0;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overflow, frame_done;

  typedef struct packed {
    logic [7:0] b;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   hs_total = 0, fd_pulses = 0;
  int   rdy_mode = 1;  // 0 = low, 1 = high, 2 = random

  always #5 clk = ~clk;

  fft_byte_packer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_valid  (in_valid),
    .in_index  (in_index),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask

  // Reference: a kept sample becomes an optional A5 plus its 8 bytes
  function automatic void model_add(input logic [31:0] re, input logic [31:0] im,
                                    input logic [15:0] idx);
    logic [63:0] s;
    exp_t        e;
    s = {re, im};
    if (idx == 16'd0) begin
      e.b = 8'hA5; e.fd = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      e.b  = 8'((s >> (56 - 8*k)) & 64'hFF);
      e.fd = (k == 7) && (idx == 16'(FLEN - 1));
      exp_q.push_back(e);
    end
  endfunction

  task automatic push(input logic [31:0] re, input logic [31:0] im,
                      input logic [15:0] idx, input bit keep);
    in_re = re; in_im = im; in_index = idx; in_valid = 1'b1;
    if (keep) model_add(re, im, idx);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: byte order, hold-while-stalled, idle, frame_done timing
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       fd_exp = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      fd_exp     = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done) fd_pulses++;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_byte", 32'(out_byte), 32'(prev_byte));
      end
      fd_exp = 1'b0;
      if (exp_q.size() == 0) begin
        chk("idle_valid", 32'(out_valid), 32'd0);
      end else if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk("byte", 32'(out_byte), 32'(e.b));
        fd_exp = e.fd;
        hs_total++;
      end
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, h0, n, nb;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_byte", 32'(out_byte), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single sample, latency 2 cycles, no sync byte
    @(posedge clk); #1;
    push(32'h12345678, 32'hFEDCBA98, 16'd5, 1'b1);
    @(negedge clk);
    chk("lat_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_c2", 32'(out_valid), 32'd1);
    chk("lat_byte0", 32'(out_byte), 32'h12);
    wait_drain(100);

    // Index 0 sample gets a sync byte
    push(32'h00000001, 32'hFFFFFFFF, 16'd0, 1'b1);
    wait_drain(100);

    // Full frame back to back: exactly one frame_done pulse
    fd0 = fd_pulses;
    for (int i = 0; i < FLEN; i++) push($urandom, $urandom, 16'(i), 1'b1);
    wait_drain(300);
    chk("frame_pulses", 32'(fd_pulses - fd0), 32'd1);
    chk("ovf_frame", 32'(overflow), 32'd0);

    // Random ready with random bursts that cannot overflow from a drained state
    rdy_mode = 2;
    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(1, DEPTH);
      for (int i = 0; i < nb; i++) begin
        push($urandom, $urandom, 16'($urandom_range(0, FLEN - 1)), 1'b1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
      end
      wait_drain(4000);
    end

    // Overflow: stall the link with one sample in flight, then burst DEPTH+2
    rdy_mode = 0;
    @(posedge clk); #2;
    push($urandom, $urandom, 16'd3, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_pre", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH + 2; i++) push($urandom, $urandom, 16'(i + 1), i < DEPTH);
    chk("ovf_set", 32'(overflow), 32'd1);
    rdy_mode = 1;
    wait_drain(600);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset after 3 bytes of a sample; the partial sample is discarded
    h0 = hs_total;
    push(32'hA1B2C3D4, 32'h0BADF00D, 16'd2, 1'b1);
    n = 0;
    while (hs_total < h0 + 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("rst_mid_reach", 32'(hs_total >= h0 + 3), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rmid_valid", 32'(out_valid), 32'd0);
    chk("rmid_byte", 32'(out_byte), 32'd0);
    chk("rmid_ovf", 32'(overflow), 32'd0);
    chk("rmid_fd", 32'(frame_done), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(32'h55667788, 32'h99AABBCC, 16'd4, 1'b1);
    wait_drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
